bus_master_port: RTL
====================

# bus_master_port

Master-side bus port placed directly upstream of the two-master arbiter. It accepts one read or write command from a local requester, raises the arbiter request, waits for grant, and serialises a mode bit, address and (for writes) data onto the shared bus. It then collects serial read data, or aborts on lost grant or missing slave acknowledge, and reports completion to the requester. One instance per master; its `req` drives `m1_req`/`m2_req` and its `grant` is driven by `m1_grant`/`m2_grant`.

## Interface
Parameters:
- `ADDR_WIDTH`, 12, address bits sent per frame
- `DATA_WIDTH`, 8, data bits per transfer
- `ACK_TIMEOUT`, 16, cycles allowed in WAIT_ACK before abort (only used when the timeout feature is compiled in)

Ports:
- `clk` in 1: single clock; all logic on the rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: command strobe, sampled only in IDLE
- `rw` in 1: 1 = write, 0 = read; captured with `start`
- `addr` in ADDR_WIDTH: target address; captured with `start`
- `wdata` in DATA_WIDTH: write data; captured with `start`
- `busy` out 1: high from the cycle after an accepted `start` until the cycle after `done`
- `done` out 1: one-cycle completion pulse
- `err` out 1: valid with `done`; 1 = aborted
- `rdata` out DATA_WIDTH: read result; valid with `done` when `rw=0` and `err=0`; holds its value until the next read completes
- `req` out 1: arbiter request
- `grant` in 1: arbiter grant for this master
- `tx_bit` out 1: serial bus data out
- `tx_valid` out 1: `tx_bit` is meaningful this cycle
- `ack` in 1: slave address acknowledge
- `rx_bit` in 1: serial read data from slave
- `rx_valid` in 1: `rx_bit` is meaningful this cycle

## Operation
- **States:** IDLE, REQ, ADDR, WAIT_ACK, WDATA, RDATA, DONE.
- **IDLE:** when `start`=1, capture `rw`/`addr`/`wdata` and go to REQ. `start` in any other state is ignored.
- **REQ:** `req`=1. When `grant`=1, go to ADDR.
- **ADDR:** frame is the `rw` bit, then `addr` LSB first. That is 1+ADDR_WIDTH consecutive cycles with `tx_valid`=1. Then go to WAIT_ACK.
- **WAIT_ACK:** `tx_valid`=0. On `ack`=1, go to WDATA if writing, otherwise RDATA.
- **WDATA:** `wdata` sent LSB first over DATA_WIDTH consecutive cycles with `tx_valid`=1. Then go to DONE.
- **RDATA:** shift `rx_bit` in LSB first on each `rx_valid`=1 cycle; gaps are allowed. After DATA_WIDTH valid bits, load `rdata` and go to DONE.
- **DONE:** `done`=1 for one cycle, `req`=0, then return to IDLE.
- **Request hold:** `req` stays 1 from REQ through the last ADDR/WDATA/RDATA cycle.
- **Lost grant:** if `grant`=0 in any cycle of ADDR, WAIT_ACK, WDATA or RDATA, go to DONE with `err`=1. `tx_valid` drops in that same cycle (combinational on `grant`).
- **Ignored inputs:** `ack` outside WAIT_ACK and `rx_valid` outside RDATA are ignored.
- **Reset values:** `req`, `tx_bit`, `tx_valid`, `done`, `err`, `busy` are 0; `rdata` is 0; state is IDLE. Reset asserted mid-frame aborts immediately with no `done`.

## Timing
- `start` at cycle N → `busy` and `req` high at N+1.
- First `grant`=1 seen at cycle G → first frame bit at G+1.
- Write, zero-wait `ack` (ack at the first WAIT_ACK cycle): `done` = G+1 + (1+ADDR_WIDTH) + 1 + DATA_WIDTH. With defaults: G+23.
- Read: `done` is the cycle after the DATA_WIDTH-th `rx_valid`.
- `busy` drops the cycle after `done`. A new `start` is accepted in that same cycle (back-to-back).

## Configuration
- `BUS_MASTER_TIMEOUT_EN` defined: a counter runs in WAIT_ACK. If `ack` has not arrived after ACK_TIMEOUT cycles, go to DONE with `err`=1. The counter is cleared on entry to WAIT_ACK.
- Not defined: WAIT_ACK waits indefinitely; `err` is set only by lost grant.

## Structure
- **Package `bus_pkg`:** state enum `bm_state_t`, constants `BUS_MODE_WRITE`=1'b1 / `BUS_MODE_READ`=1'b0, and default width constants shared with the arbiter and slave ports.
- **Sub-module `bus_shift_reg`:** parameterised width, `load`/`shift_en`, serial in and out, LSB first. Two instances: PISO for address+mode/data, SIPO for read data.

## Test plan
- **Write, immediate grant and ack:** `rw`=1, `addr`=0xA5C, `wdata`=0x3C → bit stream 1, then 0xA5C LSB first, then 0x3C LSB first; `done`=1, `err`=0 at G+23.
- **Read with gapped `rx_valid`:** slave returns 0x96 with one idle cycle between bits → `rdata`=0x96 with `done`, `err`=0.
- **Grant delayed 5 cycles:** `req` stays 1 with `tx_valid`=0 throughout; first bit on the cycle after `grant`.
- **Grant removed at the 4th address bit** → `tx_valid`=0 that cycle, `done`=1 and `err`=1 next cycle, `req`=0.
- **No `ack`, `BUS_MASTER_TIMEOUT_EN` defined, ACK_TIMEOUT=16** → `done`/`err`=1 after 16 WAIT_ACK cycles. Without the macro, the port stays in WAIT_ACK and `busy` remains 1.
- **`rst_n` pulsed low mid-WDATA** → all outputs 0 immediately; a subsequent `start` completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus: master-port state encoding,
// frame mode bit values and default widths used by the arbiter and slave ports.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        ADDR     = 3'd2,
        WAIT_ACK = 3'd3,
        WDATA    = 3'd4,
        RDATA    = 3'd5,
        DONE     = 3'd6
    } bm_state_t;

    localparam logic BUS_MODE_WRITE = 1'b1;
    localparam logic BUS_MODE_READ  = 1'b0;

    localparam int BUS_ADDR_WIDTH  = 12;
    localparam int BUS_DATA_WIDTH  = 8;
    localparam int BUS_ACK_TIMEOUT = 16;

endpackage

// File: rtl/bus_shift_reg.sv
// LSB-first shift register with parallel load, used both as the transmit
// PISO and the receive SIPO. New serial bits enter at the MSB.
module bus_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] par_in,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next contents: a parallel load takes priority over a shift.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = par_in;
        end else if (shift_en) begin
            data_d = {ser_in, data_q[WIDTH-1:1]};
        end else begin
            data_d = data_q;
        end
    end

    // Storage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign par_out = data_q;
    assign ser_out = data_q[0];

endmodule

// File: rtl/bus_master_port.sv
// Master-side serial bus port: takes one read/write command, requests the
// arbiter, sends mode+address (and write data) LSB first, collects read data
// and reports completion. Optional WAIT_ACK timeout is compiled in with the
// macro BUS_MASTER_TIMEOUT_EN.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH  = BUS_DATA_WIDTH,
    parameter int ACK_TIMEOUT = BUS_ACK_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  req,
    input  logic                  grant,
    output logic                  tx_bit,
    output logic                  tx_valid,
    input  logic                  ack,
    input  logic                  rx_bit,
    input  logic                  rx_valid
);

    // Whole outgoing frame is loaded at once: mode bit, address, write data.
    localparam int FRAME_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_d;
`else
    localparam int ACK_TIMEOUT_UNUSED = ACK_TIMEOUT;
`endif

    bm_state_t             state_q;
    bm_state_t             state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  rw_q;
    logic                  rw_d;
    logic                  err_q;
    logic                  err_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    logic                  piso_load_s;
    logic                  piso_ser_s;
    logic [FRAME_W-1:0]    piso_unused_s;
    logic                  tx_valid_s;
    logic                  sipo_shift_s;
    logic [DATA_WIDTH-1:0] sipo_par_s;
    logic                  sipo_unused_s;
    logic [DATA_WIDTH-1:0] sipo_next_s;

    // Bus is driven only while this master still holds grant.
    assign tx_valid_s   = ((state_q == ADDR) || (state_q == WDATA)) && grant;
    assign sipo_shift_s = (state_q == RDATA) && grant && rx_valid;
    assign sipo_next_s  = {rx_bit, sipo_par_s[DATA_WIDTH-1:1]};

    bus_shift_reg #(.WIDTH(FRAME_W)) u_piso (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (piso_load_s),
        .par_in   ({wdata, addr, rw}),
        .shift_en (tx_valid_s),
        .ser_in   (1'b0),
        .par_out  (piso_unused_s),
        .ser_out  (piso_ser_s)
    );

    bus_shift_reg #(.WIDTH(DATA_WIDTH)) u_sipo (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .par_in   ({DATA_WIDTH{1'b0}}),
        .shift_en (sipo_shift_s),
        .ser_in   (rx_bit),
        .par_out  (sipo_par_s),
        .ser_out  (sipo_unused_s)
    );

    // Next-state, bit counting, abort handling and read-data capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        piso_load_s = 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (start) begin
                    rw_d        = rw;
                    piso_load_s = 1'b1;
                    cnt_d       = '0;
                    state_d     = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (grant) begin
                    cnt_d   = '0;
                    state_d = ADDR;
                end else begin
                    state_d = REQ;
                end
            end
            ADDR: begin
                if (!grant) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
`ifdef BUS_MASTER_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                    state_d = WAIT_ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_ACK: begin
                if (!grant) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (ack) begin
                    cnt_d   = '0;
                    state_d = (rw_q == BUS_MODE_WRITE) ? WDATA : RDATA;
`ifdef BUS_MASTER_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`else
                end else begin
                    state_d = WAIT_ACK;
                end
`endif
            end
            WDATA: begin
                if (!grant) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == LAST_DATA) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RDATA: begin
                if (!grant) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (rx_valid) begin
                    if (cnt_q == LAST_DATA) begin
                        rdata_d = sipo_next_s;
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = RDATA;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef BUS_MASTER_TIMEOUT_EN
    // Acknowledge timeout counter, restarted on every entry to WAIT_ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign req      = (state_q == REQ) || (state_q == ADDR) || (state_q == WAIT_ACK) ||
                      (state_q == WDATA) || (state_q == RDATA);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign tx_valid = tx_valid_s;
    assign tx_bit   = tx_valid_s & piso_ser_s;

endmodule
